ttc_timer_channel_gen: RTL and testbench
========================================

Name: ttc_timer_channel_gen

Overview:
- Parametrised single timer/counter channel. Successor to the fixed 16-bit, 3-match "lite" timer.
- Merges the prescaler, counter, match and interrupt functions into one block behind a flat addressed register write port.
- Adds configurable counter width and match count, down-counting, one-shot mode and W1C interrupt clear.
- One instance per channel sits under the APB timer wrapper, which owns address decode and read muxing.

Parameters:
CNT_W, 16, counter/interval/match width (8..32)
NUM_MATCH, 3, number of match registers (1..8)
PRE_W, 4, width of the prescale exponent field

Ports:
pclk  in  1  APB system clock; only clock
p_reset  in  1  synchronous active-high reset
reg_wr  in  1  register write strobe, one cycle per write
reg_addr  in  4  register index
pwdata  in  32  write data; low bits used per register
count_val  out  CNT_W  current counter value
clk_ctrl_reg  out  PRE_W+1  [0] prescale enable, [PRE_W:1] exponent P
cntr_ctrl_reg  out  6  [0] stop, [1] interval mode, [2] decrement, [3] match enable, [4] restart, [5] one-shot
interval_reg  out  CNT_W  interval value
match_regs  out  NUM_MATCH*CNT_W  match i at bits [i*CNT_W +: CNT_W]
intr_status  out  NUM_MATCH+2  [0] interval, [NUM_MATCH:1] match, [NUM_MATCH+1] overflow
intr_en  out  NUM_MATCH+2  interrupt enable mask
interrupt  out  1  OR of (intr_status & intr_en)

Behaviour:
- Interface: one clock, pclk. Reset p_reset is synchronous and active-high.
- Register map (reg_addr):
  - 0: clk_ctrl
  - 1: cntr_ctrl
  - 2: interval
  - 3..3+NUM_MATCH-1: match
  - 14: intr_en
  - 15: intr_status clear, W1C
  - Writes to unmapped addresses are ignored.
- Reset values: all outputs and registers 0, except cntr_ctrl = 6'b000001 (stopped).
- Prescaler:
  - prescale enable = 0: one tick per pclk.
  - prescale enable = 1: one tick every 2^(P+1) pclks, from a free-running PRE_W+... divider.
  - No ticks while stop = 1.
- Counting, on each tick:
  - Up, overflow mode: count+1; wraps max -> 0 and raises overflow.
  - Up, interval mode: count == interval -> next value 0, raises interval. Otherwise count+1.
  - Down, overflow mode: count-1; wraps 0 -> max and raises overflow.
  - Down, interval mode: count == 0 -> reload interval, raises interval. Otherwise count-1.
- Interval = 0 in interval mode: count holds at 0 and raises interval on every tick.
- Match: on a tick where the new count equals match i and match enable = 1, raise match i. Several matches may fire on the same tick.
- Event timing: status bits set the cycle after the tick edge that produced the count change. interrupt is combinational from the registered status and enable.
- One-shot: an interval or overflow event also sets stop in the same cycle. The count holds its wrapped value.
- Restart:
  - Writing cntr_ctrl with bit4 = 1 clears the prescaler.
  - Count loads 0 (up), interval (down, interval mode) or max (down, overflow mode).
  - Bit4 self-clears the next cycle. No event is raised by the restart.
- Write clear: a write to address 15 clears status bits where pwdata = 1. If set and clear hit the same bit in the same cycle, set wins.
- Reg writes of interval/match take effect on the next cycle's compare. Count is not reloaded, except by restart.
- p_reset mid-count: everything returns to reset values on the next edge. Pending status is lost.

Optional Feature:
- Macro TTC_WAVE_OUT_EN adds output wave_out (1 bit, reset 0).
  - wave_out toggles on each match 1 event.
  - wave_out is forced to 0 on restart.
- Without the macro: the port and its logic are absent. Behaviour is otherwise identical.

Test Plan:
1. Reset; write cntr_ctrl = 0x00 -> count_val increments 0,1,2… one per pclk. At 0xFFFF -> 0, intr_status[4] = 1. With intr_en = 0x10, interrupt = 1.
2. interval = 5, cntr_ctrl = 0x02 -> count sequence 0..5,0. intr_status[0] set one cycle after the 5->0 wrap. W1C write 0x01 clears it, unless another wrap occurs the same cycle (set wins).
3. clk_ctrl = 0x03 (P = 1, divide-by-4), match1 = 3, cntr_ctrl = 0x08 -> count advances every 4 pclks. intr_status[1] sets after count reaches 3 (~12 pclks).
4. interval = 4, cntr_ctrl = 0x26 (down, interval, one-shot) -> count 4,3,2,1,0,4 then stops. stop bit reads 1, intr_status[0] = 1.
5. Mid-count (count = 0x100), write cntr_ctrl bit4 = 1 -> count = 0 next cycle, bit4 reads 0 after, no status bit set. Then assert p_reset for 1 cycle -> all outputs at reset values.
6. TTC_WAVE_OUT_EN defined, match1 = 2, interval = 3, interval mode -> wave_out toggles once per 4-tick period.

Source files
------------

// File: rtl/ttc_timer_channel_gen.sv
// Single timer/counter channel: prescaler, up/down counter, matches, W1C interrupts.
// Optional wave_out (toggles on match 1 events) is enabled with `define TTC_WAVE_OUT_EN.
module ttc_timer_channel_gen #(
  parameter int CNT_W     = 16,
  parameter int NUM_MATCH = 3,
  parameter int PRE_W     = 4
) (
  input  logic                       pclk,
  input  logic                       p_reset,
  input  logic                       reg_wr,
  input  logic [3:0]                 reg_addr,
  input  logic [31:0]                pwdata,
  output logic [CNT_W-1:0]           count_val,
  output logic [PRE_W:0]             clk_ctrl_reg,
  output logic [5:0]                 cntr_ctrl_reg,
  output logic [CNT_W-1:0]           interval_reg,
  output logic [NUM_MATCH*CNT_W-1:0] match_regs,
  output logic [NUM_MATCH+1:0]       intr_status,
  output logic [NUM_MATCH+1:0]       intr_en,
  output logic                       interrupt
`ifdef TTC_WAVE_OUT_EN
  ,
  output logic                       wave_out
`endif
);

  localparam int DIV_W = 1 << PRE_W;
  localparam int ST_W  = NUM_MATCH + 2;
  localparam logic [CNT_W-1:0] MAXV = '1;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0]           r_count;
  logic [PRE_W:0]             r_clk_ctrl;
  logic [5:0]                 r_cntr_ctrl;
  logic [CNT_W-1:0]           r_interval;
  logic [NUM_MATCH*CNT_W-1:0] r_match;
  logic [ST_W-1:0]            r_status;
  logic [ST_W-1:0]            r_en;
  logic [DIV_W-1:0]           r_div;

  logic                 w_stop, w_intmode, w_down;
  logic                 w_men, w_rst_bit, w_oneshot;
  logic [PRE_W:0]       w_sh;
  logic [DIV_W-1:0]     w_mask;
  logic                 w_tick;
  logic [CNT_W-1:0]     w_cnt_nxt, w_load;
  logic                 w_ev_int, w_ev_ovf;
  logic [NUM_MATCH-1:0] w_mhit, w_wr_match;
  logic                 w_wr_clk, w_wr_ctrl, w_wr_int;
  logic                 w_wr_en, w_wr_clr, w_restart;
  logic [ST_W-1:0]      w_set, w_clr;
  logic                 w_unused;

  assign w_stop    = r_cntr_ctrl[0];
  assign w_intmode = r_cntr_ctrl[1];
  assign w_down    = r_cntr_ctrl[2];
  assign w_men     = r_cntr_ctrl[3];
  assign w_rst_bit = r_cntr_ctrl[4];
  assign w_oneshot = r_cntr_ctrl[5];

  // Tick when the low P+1 divider bits are all ones.
  assign w_sh   = {1'b0, r_clk_ctrl[PRE_W:1]} + (PRE_W+1)'(1);
  assign w_mask = ~({DIV_W{1'b1}} << w_sh);
  assign w_tick = !w_stop &&
    (!r_clk_ctrl[0] || ((r_div & w_mask) == w_mask));

  always_comb begin
    w_cnt_nxt = r_count;
    w_ev_int  = 1'b0;
    w_ev_ovf  = 1'b0;
    if (w_tick) begin
      unique case ({w_down, w_intmode})
        2'b00: begin
          w_cnt_nxt = r_count + ONE;
          w_ev_ovf  = (r_count == MAXV);
        end
        2'b01: begin
          if (r_count == r_interval) begin
            w_cnt_nxt = '0;
            w_ev_int  = 1'b1;
          end else begin
            w_cnt_nxt = r_count + ONE;
          end
        end
        2'b10: begin
          w_cnt_nxt = r_count - ONE;
          w_ev_ovf  = (r_count == '0);
        end
        default: begin
          if (r_count == '0) begin
            w_cnt_nxt = r_interval;
            w_ev_int  = 1'b1;
          end else begin
            w_cnt_nxt = r_count - ONE;
          end
        end
      endcase
    end
  end

  always_comb begin
    w_mhit = '0;
    for (int i = 0; i < NUM_MATCH; i++) begin
      w_mhit[i] = w_tick && w_men &&
        (w_cnt_nxt == r_match[i*CNT_W +: CNT_W]);
    end
  end

  always_comb begin
    w_wr_match = '0;
    for (int i = 0; i < NUM_MATCH; i++) begin
      w_wr_match[i] = reg_wr && (reg_addr == 4'(3 + i));
    end
  end

  assign w_wr_clk  = reg_wr && (reg_addr == 4'd0);
  assign w_wr_ctrl = reg_wr && (reg_addr == 4'd1);
  assign w_wr_int  = reg_wr && (reg_addr == 4'd2);
  assign w_wr_en   = reg_wr && (reg_addr == 4'd14);
  assign w_wr_clr  = reg_wr && (reg_addr == 4'd15);
  assign w_restart = w_wr_ctrl && pwdata[4];

  // Restart load value follows the direction/mode being written.
  always_comb begin
    if (!pwdata[2]) begin
      w_load = '0;
    end else if (pwdata[1]) begin
      w_load = r_interval;
    end else begin
      w_load = MAXV;
    end
  end

  assign w_set = w_restart ? '0 : {w_ev_ovf, w_mhit, w_ev_int};
  assign w_clr = w_wr_clr ? pwdata[ST_W-1:0] : '0;
  assign w_unused = &{1'b0, pwdata};

  always_ff @(posedge pclk) begin
    if (p_reset) begin
      r_count     <= '0;
      r_clk_ctrl  <= '0;
      r_cntr_ctrl <= 6'b000001;
      r_interval  <= '0;
      r_match     <= '0;
      r_status    <= '0;
      r_en        <= '0;
      r_div       <= '0;
    end else begin
      r_div    <= w_restart ? '0 : r_div + DIV_W'(1);
      r_count  <= w_restart ? w_load : w_cnt_nxt;
      r_status <= (r_status & ~w_clr) | w_set;
      if (w_wr_clk) r_clk_ctrl <= pwdata[PRE_W:0];
      if (w_wr_int) r_interval <= pwdata[CNT_W-1:0];
      if (w_wr_en)  r_en       <= pwdata[ST_W-1:0];
      for (int i = 0; i < NUM_MATCH; i++) begin
        if (w_wr_match[i]) begin
          r_match[i*CNT_W +: CNT_W] <= pwdata[CNT_W-1:0];
        end
      end
      if (w_wr_ctrl) begin
        r_cntr_ctrl <= pwdata[5:0];
      end else begin
        if (w_rst_bit) r_cntr_ctrl[4] <= 1'b0;
        if (w_oneshot && (w_ev_int || w_ev_ovf)) begin
          r_cntr_ctrl[0] <= 1'b1;
        end
      end
    end
  end

`ifdef TTC_WAVE_OUT_EN
  logic r_wave;

  always_ff @(posedge pclk) begin
    if (p_reset) begin
      r_wave <= 1'b0;
    end else if (w_restart) begin
      r_wave <= 1'b0;
    end else if (w_mhit[0]) begin
      r_wave <= ~r_wave;
    end
  end

  assign wave_out = r_wave;
`endif

  assign count_val     = r_count;
  assign clk_ctrl_reg  = r_clk_ctrl;
  assign cntr_ctrl_reg = r_cntr_ctrl;
  assign interval_reg  = r_interval;
  assign match_regs    = r_match;
  assign intr_status   = r_status;
  assign intr_en       = r_en;
  assign interrupt     = |(r_status & r_en);

endmodule

// File: tb/tb_ttc_timer_channel_gen.sv
// Bench for ttc_timer_channel_gen: directed plan steps plus random register
// traffic checked every cycle against an arithmetic model of the channel.
module tb_ttc_timer_channel_gen;

  localparam int CW   = 8;
  localparam int NM   = 3;
  localparam int PW   = 2;
  localparam int SW   = NM + 2;
  localparam int MAXC = (1 << CW) - 1;

  logic              pclk = 1'b0;
  logic              p_reset = 1'b1;
  logic              reg_wr = 1'b0;
  logic [3:0]        reg_addr = '0;
  logic [31:0]       pwdata = '0;
  logic [CW-1:0]     count_val;
  logic [PW:0]       clk_ctrl_reg;
  logic [5:0]        cntr_ctrl_reg;
  logic [CW-1:0]     interval_reg;
  logic [NM*CW-1:0]  match_regs;
  logic [SW-1:0]     intr_status;
  logic [SW-1:0]     intr_en;
  logic              interrupt;
`ifdef TTC_WAVE_OUT_EN
  logic              wave_out;
`endif

  ttc_timer_channel_gen #(
    .CNT_W(CW), .NUM_MATCH(NM), .PRE_W(PW)
  ) dut (
    .pclk(pclk),
    .p_reset(p_reset),
    .reg_wr(reg_wr),
    .reg_addr(reg_addr),
    .pwdata(pwdata),
    .count_val(count_val),
    .clk_ctrl_reg(clk_ctrl_reg),
    .cntr_ctrl_reg(cntr_ctrl_reg),
    .interval_reg(interval_reg),
    .match_regs(match_regs),
    .intr_status(intr_status),
    .intr_en(intr_en),
    .interrupt(interrupt)
`ifdef TTC_WAVE_OUT_EN
    ,
    .wave_out(wave_out)
`endif
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;

  int unsigned m_cnt, m_clk, m_ctrl, m_int;
  int unsigned m_st, m_en, m_div;
  int unsigned m_match [NM];
  bit          m_wave;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Next state from the behavioural rules, using the inputs now applied.
  task automatic model_step();
    int unsigned per, ncnt, nctrl, ndiv, setv, clrv, d;
    bit tick, evi, evo, dn, im;
    if (p_reset) begin
      m_cnt = 0; m_clk = 0; m_ctrl = 1; m_int = 0;
      m_st = 0; m_en = 0; m_div = 0; m_wave = 0;
      for (int i = 0; i < NM; i++) m_match[i] = 0;
      return;
    end
    per  = 1 << (((m_clk >> 1) & 3) + 1);
    tick = !(m_ctrl & 1) &&
           (!(m_clk & 1) || (m_div % per) == per - 1);
    ncnt = m_cnt; evi = 0; evo = 0; setv = 0; clrv = 0;
    dn = (m_ctrl >> 2) & 1;
    im = (m_ctrl >> 1) & 1;
    if (tick) begin
      if (!dn && !im) begin
        if (m_cnt == MAXC) begin ncnt = 0; evo = 1; end
        else ncnt = m_cnt + 1;
      end else if (!dn && im) begin
        if (m_cnt == m_int) begin ncnt = 0; evi = 1; end
        else ncnt = (m_cnt + 1) % (MAXC + 1);
      end else if (dn && !im) begin
        if (m_cnt == 0) begin ncnt = MAXC; evo = 1; end
        else ncnt = m_cnt - 1;
      end else begin
        if (m_cnt == 0) begin ncnt = m_int; evi = 1; end
        else ncnt = m_cnt - 1;
      end
      if ((m_ctrl >> 3) & 1) begin
        for (int i = 0; i < NM; i++)
          if (ncnt == m_match[i]) setv |= 1 << (i + 1);
      end
    end
    setv |= (evi ? 1 : 0) | (evo ? (1 << (NM + 1)) : 0);
    if (setv & 2) m_wave = !m_wave;
    nctrl = m_ctrl;
    if (nctrl & 16) nctrl &= ~32'd16;
    if ((m_ctrl & 32) && (evi || evo)) nctrl |= 1;
    ndiv = m_div + 1;
    if (reg_wr) begin
      d = pwdata;
      if (reg_addr == 0) m_clk = d & 7;
      if (reg_addr == 1) begin
        nctrl = d & 63;
        if (d & 16) begin
          if (!(d & 4)) ncnt = 0;
          else if (d & 2) ncnt = m_int;
          else ncnt = MAXC;
          ndiv = 0; setv = 0; m_wave = 0;
        end
      end
      if (reg_addr == 2) m_int = d & MAXC;
      if (reg_addr >= 3 && reg_addr < 3 + NM)
        m_match[reg_addr - 3] = d & MAXC;
      if (reg_addr == 14) m_en = d & 31;
      if (reg_addr == 15) clrv = d & 31;
    end
    m_st   = (m_st & ~clrv) | setv;
    m_cnt  = ncnt;
    m_ctrl = nctrl;
    m_div  = ndiv;
  endtask

  task automatic check_all();
    logic [NM*CW-1:0] em;
    for (int i = 0; i < NM; i++) em[i*CW +: CW] = CW'(m_match[i]);
    chk("count", 64'(count_val), 64'(m_cnt));
    chk("clk_ctrl", 64'(clk_ctrl_reg), 64'(m_clk));
    chk("cntr_ctrl", 64'(cntr_ctrl_reg), 64'(m_ctrl));
    chk("interval", 64'(interval_reg), 64'(m_int));
    chk("match", 64'(match_regs), 64'(em));
    chk("status", 64'(intr_status), 64'(m_st));
    chk("intr_en", 64'(intr_en), 64'(m_en));
    chk("irq", 64'(interrupt), 64'((m_st & m_en) != 0));
`ifdef TTC_WAVE_OUT_EN
    chk("wave", 64'(wave_out), 64'(m_wave));
`endif
  endtask

  task automatic step();
    model_step();
    @(posedge pclk);
    #1;
    reg_wr  = 1'b0;
    p_reset = 1'b0;
    check_all();
  endtask

  task automatic wr(input int a, input int unsigned d);
    reg_addr = 4'(a);
    pwdata   = d;
    reg_wr   = 1'b1;
    step();
  endtask

  task automatic do_reset();
    p_reset = 1'b1;
    step();
  endtask

  initial begin
    int n;
    int r;
    int unsigned seq [5];

    // 1: free-running up count and overflow
    do_reset();
    chk("rst_count", 64'(count_val), 64'd0);
    chk("rst_ctrl", 64'(cntr_ctrl_reg), 64'h01);
    chk("rst_status", 64'(intr_status), 64'd0);
    chk("rst_irq", 64'(interrupt), 64'd0);
    wr(1, 32'h00);
    chk("t1_c0", 64'(count_val), 64'd0);
    step(); chk("t1_c1", 64'(count_val), 64'd1);
    step(); chk("t1_c2", 64'(count_val), 64'd2);
    repeat (253) step();
    chk("t1_max", 64'(count_val), 64'd255);
    chk("t1_nost", 64'(intr_status), 64'd0);
    wr(14, 32'h10);
    chk("t1_wrap", 64'(count_val), 64'd0);
    chk("t1_ovf", 64'(intr_status), 64'h10);
    chk("t1_irq", 64'(interrupt), 64'd1);

    // 2: interval mode, W1C, set wins over clear
    do_reset();
    wr(2, 5);
    wr(1, 32'h12);
    chk("t2_rs", 64'(count_val), 64'd0);
    chk("t2_bit4", 64'(cntr_ctrl_reg), 64'h12);
    for (int i = 1; i <= 5; i++) begin
      step(); chk("t2_seq", 64'(count_val), 64'(i));
    end
    chk("t2_ctrl", 64'(cntr_ctrl_reg), 64'h02);
    step();
    chk("t2_wrap", 64'(count_val), 64'd0);
    chk("t2_int", 64'(intr_status), 64'h01);
    wr(15, 32'h01);
    chk("t2_clr", 64'(intr_status), 64'h00);
    repeat (4) step();
    chk("t2_at5", 64'(count_val), 64'd5);
    wr(15, 32'h01);
    chk("t2_setwin", 64'(intr_status), 64'h01);

    // 3: prescale divide-by-4 with match 1
    do_reset();
    wr(0, 32'h03);
    wr(3, 3);
    wr(1, 32'h08);
    n = 0;
    while (!intr_status[1] && n < 64) begin
      step();
      n++;
    end
    chk("t3_match", 64'(intr_status[1]), 64'd1);
    chk("t3_cnt", 64'(count_val), 64'd3);
    chk("t3_cyc", 64'(n), 64'd9);
    repeat (3) step();
    chk("t3_hold", 64'(count_val), 64'd3);
    step();
    chk("t3_next", 64'(count_val), 64'd4);

    // 4: down interval one-shot
    do_reset();
    wr(2, 4);
    wr(1, 32'h36);
    chk("t4_load", 64'(count_val), 64'd4);
    seq = '{3, 2, 1, 0, 4};
    for (int i = 0; i < 5; i++) begin
      step(); chk("t4_seq", 64'(count_val), 64'(seq[i]));
    end
    chk("t4_stop", 64'(cntr_ctrl_reg), 64'h27);
    chk("t4_int", 64'(intr_status), 64'h01);
    repeat (3) step();
    chk("t4_hold", 64'(count_val), 64'd4);

    // 5: restart mid-count, then reset
    do_reset();
    wr(1, 32'h00);
    repeat (64) step();
    chk("t5_mid", 64'(count_val), 64'h40);
    wr(1, 32'h10);
    chk("t5_rs", 64'(count_val), 64'd0);
    step();
    chk("t5_bit4", 64'(cntr_ctrl_reg), 64'h00);
    chk("t5_run", 64'(count_val), 64'd1);
    chk("t5_nost", 64'(intr_status), 64'd0);
    wr(14, 32'h1f);
    wr(2, 9);
    do_reset();
    chk("t5_rcnt", 64'(count_val), 64'd0);
    chk("t5_rctl", 64'(cntr_ctrl_reg), 64'h01);
    chk("t5_ren", 64'(intr_en), 64'd0);
    chk("t5_rint", 64'(interval_reg), 64'd0);

`ifdef TTC_WAVE_OUT_EN
    // 6: wave output toggles once per 4-tick period
    do_reset();
    wr(3, 2);
    wr(2, 3);
    wr(1, 32'h1A);
    chk("t6_w0", 64'(wave_out), 64'd0);
    repeat (2) step();
    chk("t6_w1", 64'(wave_out), 64'd1);
    repeat (4) step();
    chk("t6_w2", 64'(wave_out), 64'd0);
`endif

    // random register traffic against the model
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        p_reset = 1'b1;
      end else if (r < 16) begin
        reg_wr   = 1'b1;
        reg_addr = 4'($urandom_range(0, 15));
        pwdata   = $urandom;
        if (reg_addr == 4'd1 && $urandom_range(0, 3) != 0)
          pwdata[0] = 1'b0;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
